// File: rtl/iter_counter_if.sv
// Command/status bundle for iter_counter.
// The master drives load/count requests; the slave (the counter) returns
// the count value and its status flags.
interface iter_counter_if #(
  parameter int WIDTH = 5
);
  logic             ld;
  logic             ld_ext;
  logic [WIDTH-1:0] ld_val;
  logic             dec;
  logic             inc;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc;
  logic             uflow;

  modport master (
    output ld, ld_ext, ld_val, dec, inc,
    input  out, zero, tc, uflow
  );

  modport slave (
    input  ld, ld_ext, ld_val, dec, inc,
    output out, zero, tc, uflow
  );
endinterface

// File: rtl/iter_counter.sv
// Loadable up/down iteration counter with a terminal-count pulse.
// A decrement from 1 to 0 raises tc for one cycle. Loads take either the
// external ld_val or the built-in LOAD_VAL constant.
// Compile-time option: define ITER_COUNTER_SAT_EN to make a decrement at
// zero saturate and set the sticky uflow flag. Without it, a decrement at
// zero wraps to all-ones and uflow is tied low.
module iter_counter #(
  parameter int WIDTH    = 5,
  parameter int LOAD_VAL = 16
) (
  input logic          clk,
  input logic          rst,
  iter_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] LOAD_CONST = WIDTH'(LOAD_VAL);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             uflow_q, uflow_d;

  logic dec_only;
  logic inc_only;
  logic at_zero;

  // A simultaneous inc and dec cancels out, so only one-sided requests count.
  assign dec_only = bus.dec & ~bus.inc;
  assign inc_only = bus.inc & ~bus.dec;
  assign at_zero  = (out_q == '0);

  // Next-state selection. Load takes priority over counting, and reset
  // overrides everything in the register block below.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
`ifdef ITER_COUNTER_SAT_EN
    uflow_d = uflow_q;
`else
    uflow_d = 1'b0;
`endif
    if (bus.ld) begin
      out_d   = bus.ld_ext ? bus.ld_val : LOAD_CONST;
      uflow_d = 1'b0;
    end else if (dec_only) begin
      if (at_zero) begin
`ifdef ITER_COUNTER_SAT_EN
        out_d   = '0;
        uflow_d = 1'b1;
`else
        out_d   = out_q - ONE;
`endif
      end else begin
        out_d = out_q - ONE;
        // tc only fires when a decrement reaches zero, never via wrap or load.
        tc_d  = (out_q == ONE);
      end
    end else if (inc_only) begin
      out_d = out_q + ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      tc_q    <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      tc_q    <= tc_d;
      uflow_q <= uflow_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.tc    = tc_q;
  assign bus.uflow = uflow_q;
  assign bus.zero  = at_zero;

endmodule

// File: tb/tb_iter_counter.sv
// Randomised and directed bench for iter_counter.
// The driver computes the expected state from the counter rules and
// queues it. The monitor pops one entry per clock edge and compares it
// with what the counter presents.
module tb_iter_counter;

  localparam int W  = 5;
  localparam int LV = 16;
  localparam int M  = 1 << W;

`ifdef ITER_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    int cnt;
    int tc;
    int uf;
    int zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iter_counter_if #(.WIDTH(W)) bus ();

  iter_counter #(.WIDTH(W), .LOAD_VAL(LV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;
  int   m_cnt    = 0;
  int   m_uf     = 0;
  bit   drv_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) begin
      n_pass++;
    end else begin
      $display("FAIL %s txn %0d: got %0d expected %0d", name, n_txn, act, req);
    end
  endtask

  // One transaction: drive the inputs for the next edge and queue the
  // expected result of that edge.
  task automatic step(input bit r, input bit l, input bit le, input int lv,
                      input bit d, input bit i);
    exp_t e;
    int   old;
    @(negedge clk);
    rst        = r;
    bus.ld     = l;
    bus.ld_ext = le;
    bus.ld_val = W'(lv);
    bus.dec    = d;
    bus.inc    = i;
    old  = m_cnt;
    e.tc = 0;
    if (r) begin
      m_cnt = 0;
      m_uf  = 0;
    end else if (l) begin
      m_cnt = le ? (lv % M) : LV;
      m_uf  = 0;
    end else if (d && !i) begin
      if (old == 0) begin
        if (SAT) m_uf = 1;
        else     m_cnt = M - 1;
      end else begin
        m_cnt = old - 1;
        e.tc  = (old == 1) ? 1 : 0;
      end
    end else if (i && !d) begin
      m_cnt = (old + 1) % M;
    end
    e.cnt  = m_cnt;
    e.uf   = m_uf;
    e.zero = (m_cnt == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: after every edge, compare against the oldest queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: out=%0d tc=%0d uflow=%0d zero=%0d", n_txn,
                 bus.out, bus.tc, bus.uflow, bus.zero);
        check("out",   int'(bus.out),   e.cnt);
        check("tc",    int'(bus.tc),    e.tc);
        check("uflow", int'(bus.uflow), e.uf);
        check("zero",  int'(bus.zero),  e.zero);
      end
    end
  end

  // Stimulus: directed scenarios first, then random traffic.
  initial begin
    bus.ld     = 1'b0;
    bus.ld_ext = 1'b0;
    bus.ld_val = '0;
    bus.dec    = 1'b0;
    bus.inc    = 1'b0;

    // Reset wins over a simultaneous load and decrement.
    step(1, 1, 0, 0, 1, 0);
    // Load the default constant, then count down through zero.
    step(0, 1, 0, 0, 0, 0);
    repeat (16) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    // External load ignores a decrement in the same cycle; inc+dec holds.
    step(0, 1, 1, 3, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    // Increment wraps from all-ones to zero without tc.
    step(0, 1, 1, M - 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // Decrement at zero: saturate or wrap depending on the build.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0);
    // Reset during a countdown, then reload the default constant.
    step(0, 1, 1, 7, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Random traffic with occasional resets and loads.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, M - 1),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end
    step(0, 0, 0, 0, 0, 0);
    drv_done = 1'b1;
  end

  // End of run: give the monitor a few edges to drain, then summarise.
  initial begin
    wait (drv_done);
    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
